// File: rtl/fetch_pkg.sv
//------------------------------------------------------------------------------
// Module  : fetch_pkg
// Purpose : Shared fetch/decode constants: FSM states, halt opcode and the
//           instruction-word field layout.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 20;

    localparam logic [1:0] HALT_OP_DEF = 2'b11;

    // Instruction word layout, shared with the decode stage
    localparam int OP_W    = 2;
    localparam int FIELD_W = 6;
    localparam int OP_MSB  = 19;
    localparam int OP_LSB  = 18;
    localparam int A_MSB   = 17;
    localparam int A_LSB   = 12;
    localparam int B_MSB   = 11;
    localparam int B_LSB   = 6;
    localparam int C_MSB   = 5;
    localparam int C_LSB   = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_HALTED = 3'd4
    } fetch_state_e;

    function automatic logic [OP_W-1:0] word_opcode(input logic [DATA_W_DEF-1:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch.sv
//------------------------------------------------------------------------------
// Module  : inst_fetch
// Purpose : Program counter and single-word read initiator for the 32x20-bit
//           instruction memory; presents split instructions over valid/ready.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module inst_fetch
    import fetch_pkg::*;
#(
    parameter int               ADDR_W   = ADDR_W_DEF,
    parameter int               DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] START_PC = '0,
    parameter logic [OP_W-1:0]  HALT_OP  = HALT_OP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               mem_enable,
    output logic               mem_read_writenot,
    output logic [ADDR_W-1:0]  mem_read_address,
    input  logic [DATA_W-1:0]  mem_out_data,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [OP_W-1:0]    inst_opcode,
    output logic [FIELD_W-1:0] inst_field_a,
    output logic [FIELD_W-1:0] inst_field_b,
    output logic [FIELD_W-1:0] inst_field_c,
    output logic [ADDR_W-1:0]  inst_pc,
    output logic               busy,
    output logic               halted
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= START_PC;
            word_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            word_q    <= word_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        word_d    = word_q;
        inst_pc_d = inst_pc_q;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                // redirect is meaningless while not fetching; start alone matters
                if (start) begin
                    pc_d    = START_PC;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    pc_d    = redirect_addr;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A redirect discards the returning word before it is captured
                if (redirect) begin
                    pc_d    = redirect_addr;
                    state_d = ST_REQ;
                end else begin
                    word_d    = mem_out_data;
                    inst_pc_d = pc_q;
                    if (mem_out_data[OP_MSB:OP_LSB] == HALT_OP) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_addr;
                    state_d = ST_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_enable        = (state_q == ST_REQ);
    assign mem_read_writenot = 1'b1;
    assign mem_read_address  = pc_q;

    assign inst_valid   = (state_q == ST_HOLD);
    assign inst_opcode  = word_q[OP_MSB:OP_LSB];
    assign inst_field_a = word_q[A_MSB:A_LSB];
    assign inst_field_b = word_q[B_MSB:B_LSB];
    assign inst_field_c = word_q[C_MSB:C_LSB];
    assign inst_pc      = inst_pc_q;

    assign busy   = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_HOLD);
    assign halted = (state_q == ST_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
//------------------------------------------------------------------------------
// Module  : tb_inst_fetch
// Purpose : Self-checking bench for inst_fetch with a registered memory model.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        redirect = 1'b0;
    logic [4:0]  redirect_addr = '0;
    logic        inst_ready = 1'b0;
    logic [19:0] mem_out_data = '0;

    logic        mem_enable;
    logic        mem_read_writenot;
    logic [4:0]  mem_read_address;
    logic        inst_valid;
    logic [1:0]  inst_opcode;
    logic [5:0]  inst_field_a;
    logic [5:0]  inst_field_b;
    logic [5:0]  inst_field_c;
    logic [4:0]  inst_pc;
    logic        busy;
    logic        halted;

    logic [19:0] mem [32];
    int          ops [8] = '{0, 1, 2, 1, 0, 2, 1, 3};
    int          checks = 0;
    int          passes = 0;

    inst_fetch dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .redirect          (redirect),
        .redirect_addr     (redirect_addr),
        .mem_enable        (mem_enable),
        .mem_read_writenot (mem_read_writenot),
        .mem_read_address  (mem_read_address),
        .mem_out_data      (mem_out_data),
        .inst_valid        (inst_valid),
        .inst_ready        (inst_ready),
        .inst_opcode       (inst_opcode),
        .inst_field_a      (inst_field_a),
        .inst_field_b      (inst_field_b),
        .inst_field_c      (inst_field_c),
        .inst_pc           (inst_pc),
        .busy              (busy),
        .halted            (halted)
    );

    always #5 clk = ~clk;

    // Memory registers the addressed word on the request edge
    always @(posedge clk) begin
        if (mem_enable) mem_out_data <= mem[mem_read_address];
    end

    function automatic logic [19:0] mk(input int op, input int a, input int b, input int c);
        return {2'(op), 6'(a), 6'(b), 6'(c)};
    endfunction

    task automatic load_program();
        for (int i = 0; i < 8; i++) mem[i] = mk(ops[i], 3 * i, 3 * i + 1, 3 * i + 2);
        for (int i = 8; i < 32; i++) mem[i] = mk(i % 3, i, i + 1, i + 2);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({inst_valid, busy, halted, mem_enable} !== 4'b0000)
            $display("FAIL reset_flags got v/b/h/e=%b want 0000", {inst_valid, busy, halted, mem_enable});
        else passes++;
        checks++; if ({inst_opcode, inst_field_a, inst_field_b, inst_field_c} !== 20'd0)
            $display("FAIL reset_fields got %h want 0", {inst_opcode, inst_field_a, inst_field_b, inst_field_c});
        else passes++;
        checks++; if ({mem_read_address, inst_pc} !== 10'd0)
            $display("FAIL reset_addr got addr=%0d pc=%0d want 0/0", mem_read_address, inst_pc);
        else passes++;
        checks++; if (mem_read_writenot !== 1'b1)
            $display("FAIL reset_rwn got %b want 1", mem_read_writenot);
        else passes++;
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({busy, mem_enable, halted} !== 3'b000)
            $display("FAIL idle_no_start got b/e/h=%b want 000", {busy, mem_enable, halted});
        else passes++;
    endtask

    task automatic test_program();
        inst_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            checks++; if (mem_enable !== 1'b1 || mem_read_address !== 5'(k))
                $display("FAIL prog_req k=%0d got en=%b addr=%0d want 1/%0d", k, mem_enable, mem_read_address, k);
            else passes++;
            @(negedge clk);
            checks++; if ({busy, mem_enable, inst_valid} !== 3'b100)
                $display("FAIL prog_wait k=%0d got b/e/v=%b want 100", k, {busy, mem_enable, inst_valid});
            else passes++;
            @(negedge clk);
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 5'(k) ||
                {inst_opcode, inst_field_a, inst_field_b, inst_field_c} !== mk(ops[k], 3 * k, 3 * k + 1, 3 * k + 2))
                $display("FAIL prog_hold k=%0d got v=%b pc=%0d word=%h want 1/%0d/%h", k, inst_valid, inst_pc,
                         {inst_opcode, inst_field_a, inst_field_b, inst_field_c}, k, mk(ops[k], 3 * k, 3 * k + 1, 3 * k + 2));
            else passes++;
            @(negedge clk);
        end
        checks++; if (mem_enable !== 1'b1 || mem_read_address !== 5'd7)
            $display("FAIL prog_req7 got en=%b addr=%0d want 1/7", mem_enable, mem_read_address);
        else passes++;
        @(negedge clk);
        @(negedge clk);
        checks++; if ({halted, inst_valid, busy, mem_enable} !== 4'b1000)
            $display("FAIL prog_halt got h/v/b/e=%b want 1000", {halted, inst_valid, busy, mem_enable});
        else passes++;
    endtask

    task automatic test_stall();
        bit found = 1'b0;
        logic [19:0] exp_word = mk(1, 9, 10, 11);
        inst_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (halted !== 1'b0 || mem_enable !== 1'b1 || mem_read_address !== 5'd0)
            $display("FAIL restart got h=%b en=%b addr=%0d want 0/1/0", halted, mem_enable, mem_read_address);
        else passes++;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (inst_valid && inst_pc == 5'd3) found = 1'b1;
        end
        checks++; if (!found) $display("FAIL stall_reach got timeout want valid at pc 3");
        else passes++;
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (inst_valid !== 1'b1 || mem_enable !== 1'b0 || inst_pc !== 5'd3 ||
                {inst_opcode, inst_field_a, inst_field_b, inst_field_c} !== exp_word)
                $display("FAIL stall_hold i=%0d got v=%b en=%b pc=%0d word=%h want 1/0/3/%h", i, inst_valid,
                         mem_enable, inst_pc, {inst_opcode, inst_field_a, inst_field_b, inst_field_c}, exp_word);
            else passes++;
        end
        inst_ready = 1'b1;
        @(negedge clk);
        checks++; if (mem_enable !== 1'b1 || mem_read_address !== 5'd4)
            $display("FAIL stall_release got en=%b addr=%0d want 1/4", mem_enable, mem_read_address);
        else passes++;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (halted) found = 1'b1;
        end
        checks++; if (!found) $display("FAIL stall_halt got timeout want halted");
        else passes++;
    endtask

    task automatic test_redirect();
        bit found = 1'b0;
        inst_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_enable && mem_read_address == 5'd1) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found) $display("FAIL redir_reach got timeout want request at 1");
        else passes++;
        @(negedge clk);
        checks++; if ({busy, mem_enable, inst_valid} !== 3'b100)
            $display("FAIL redir_wait got b/e/v=%b want 100", {busy, mem_enable, inst_valid});
        else passes++;
        redirect = 1'b1;
        redirect_addr = 5'd5;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (mem_enable !== 1'b1 || mem_read_address !== 5'd5 || inst_valid !== 1'b0)
            $display("FAIL redir_req got en=%b addr=%0d v=%b want 1/5/0", mem_enable, mem_read_address, inst_valid);
        else passes++;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (inst_valid) found = 1'b1;
        end
        checks++;
        if (!found || inst_pc !== 5'd5 || {inst_opcode, inst_field_a, inst_field_b, inst_field_c} !== mk(2, 15, 16, 17))
            $display("FAIL redir_target got v=%b pc=%0d word=%h want 1/5/%h", inst_valid, inst_pc,
                     {inst_opcode, inst_field_a, inst_field_b, inst_field_c}, mk(2, 15, 16, 17));
        else passes++;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (halted) found = 1'b1;
        end
        checks++; if (!found) $display("FAIL redir_halt got timeout want halted");
        else passes++;
    endtask

    task automatic test_wrap();
        bit found = 1'b0;
        mem[7] = mk(0, 21, 22, 23);
        inst_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (inst_valid) found = 1'b1;
        end
        // Redirect while an instruction is being accepted: redirect must win
        redirect = 1'b1;
        redirect_addr = 5'd31;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (!found || mem_enable !== 1'b1 || mem_read_address !== 5'd31)
            $display("FAIL wrap_redir got en=%b addr=%0d want 1/31", mem_enable, mem_read_address);
        else passes++;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (inst_valid) found = 1'b1;
        end
        checks++;
        if (!found || inst_pc !== 5'd31 || {inst_opcode, inst_field_a, inst_field_b, inst_field_c} !== mk(1, 31, 32, 33))
            $display("FAIL wrap_inst got pc=%0d word=%h want 31/%h", inst_pc,
                     {inst_opcode, inst_field_a, inst_field_b, inst_field_c}, mk(1, 31, 32, 33));
        else passes++;
        @(negedge clk);
        checks++; if (mem_enable !== 1'b1 || mem_read_address !== 5'd0)
            $display("FAIL wrap_next got en=%b addr=%0d want 1/0", mem_enable, mem_read_address);
        else passes++;
        mem[7] = mk(3, 21, 22, 23);
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        inst_ready = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (inst_valid) found = 1'b1;
        end
        checks++; if (!found) $display("FAIL rstmid_reach got timeout want valid");
        else passes++;
        #2 rst = 1'b0;
        #1;
        checks++; if ({inst_valid, busy, mem_enable, halted} !== 4'b0000 || inst_pc !== 5'd0 || inst_opcode !== 2'd0)
            $display("FAIL rstmid_async got v/b/e/h=%b pc=%0d op=%0d want 0000/0/0",
                     {inst_valid, busy, mem_enable, halted}, inst_pc, inst_opcode);
        else passes++;
        @(negedge clk);
        rst = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if ({busy, mem_enable, inst_valid} !== 3'b000)
            $display("FAIL rstmid_idle got b/e/v=%b want 000", {busy, mem_enable, inst_valid});
        else passes++;
    endtask

    task automatic test_random();
        logic [4:0]  exp_pc = 5'd0;
        logic [19:0] prev_word = '0;
        bit          stable_pending = 1'b0;
        bit          prev_halted = 1'b0;
        logic [19:0] w;
        for (int i = 0; i < 32; i++) begin
            w = 20'($urandom);
            if (w[19:18] == 2'b11 && ($urandom % 6) != 0) w[19:18] = 2'($urandom % 3);
            mem[i] = w;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (mem_enable) begin
                checks++; if (mem_read_address !== exp_pc)
                    $display("FAIL rnd_addr cyc=%0d got %0d want %0d", cyc, mem_read_address, exp_pc);
                else passes++;
            end
            if (inst_valid) begin
                checks++;
                if (inst_pc !== exp_pc || {inst_opcode, inst_field_a, inst_field_b, inst_field_c} !== mem[exp_pc] ||
                    inst_opcode === 2'b11)
                    $display("FAIL rnd_inst cyc=%0d got pc=%0d word=%h want %0d/%h", cyc, inst_pc,
                             {inst_opcode, inst_field_a, inst_field_b, inst_field_c}, exp_pc, mem[exp_pc]);
                else passes++;
            end
            if (stable_pending) begin
                checks++;
                if (inst_valid !== 1'b1 || {inst_opcode, inst_field_a, inst_field_b, inst_field_c} !== prev_word)
                    $display("FAIL rnd_stable cyc=%0d got v=%b word=%h want 1/%h", cyc, inst_valid,
                             {inst_opcode, inst_field_a, inst_field_b, inst_field_c}, prev_word);
                else passes++;
            end
            if (halted && !prev_halted) begin
                checks++; if (mem[exp_pc][19:18] !== 2'b11)
                    $display("FAIL rnd_halt cyc=%0d got halted at pc=%0d op=%0d want op 3", cyc, exp_pc, mem[exp_pc][19:18]);
                else passes++;
            end
            prev_halted = halted;

            inst_ready    = 1'($urandom % 2);
            redirect      = (($urandom % 10) == 0);
            redirect_addr = 5'($urandom);
            start         = busy ? (($urandom % 8) == 0) : (($urandom % 4) == 0);

            stable_pending = inst_valid && !inst_ready && !redirect;
            prev_word      = {inst_opcode, inst_field_a, inst_field_b, inst_field_c};
            if (!busy) begin
                if (start) exp_pc = 5'd0;
            end else if (redirect) begin
                exp_pc = redirect_addr;
            end else if (inst_valid && inst_ready) begin
                exp_pc = 5'((int'(exp_pc) + 1) % 32);
            end
        end
        start = 1'b0;
        redirect = 1'b0;
    endtask

    initial begin
        load_program();
        test_reset();
        test_program();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
